// File: rtl/div_pkg.sv
// Shared widths, state encoding and constants for the bit-serial divider.
package div_pkg;

   localparam int DIV_N_W   = 19;
   localparam int DIV_D_W   = 16;
   localparam int DIV_CNT_W = 5;

   localparam logic [DIV_N_W-1:0] DIV_DZ_QUOT = 19'h7FFFF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_bit_step.sv
// One restoring-division iteration: trial subtract and quotient bit.
module div_bit_step
   import div_pkg::*;
(
   input  logic [DIV_D_W-1:0] rem,
   input  logic               msb,
   input  logic [DIV_D_W-1:0] divisor,
   output logic [DIV_D_W-1:0] next_rem,
   output logic               qbit
);

   logic [DIV_D_W-1:0] shifted;
   logic [DIV_D_W-1:0] diff;

   // 17-bit compare decides the bit; low 16 bits of the difference suffice
   // because a kept result is always below the divisor.
   always_comb begin
      shifted  = {rem[DIV_D_W-2:0], msb};
      diff     = shifted - divisor;
      qbit     = ({rem, msb} >= {1'b0, divisor});
      next_rem = qbit ? diff : shifted;
   end

endmodule

// File: rtl/div_bit.sv
// Sequential unsigned restoring divider, 19-bit by 16-bit, one bit per clock.
module div_bit
   import div_pkg::*;
(
   input  logic               p_reset,
   input  logic               m_clock,
   input  logic [DIV_N_W-1:0] div_bit1,
   input  logic [DIV_D_W-1:0] div_bit2,
   input  logic               div_bit_exe,
   output logic [DIV_N_W-1:0] div_bit_quot,
   output logic [DIV_D_W-1:0] div_bit_rem,
   output logic               div_bit_busy,
   output logic               div_bit_done,
   output logic               div_bit_dz
);

   div_state_t           state;
   logic [DIV_N_W-1:0]   dvd;
   logic [DIV_D_W-1:0]   dvs;
   logic [DIV_D_W-1:0]   prem;
   logic [DIV_CNT_W-1:0] cnt;
   logic [DIV_D_W-1:0]   nrem;
   logic                 qbit;

   div_bit_step u_step (
      .rem      (prem),
      .msb      (dvd[DIV_N_W-1]),
      .divisor  (dvs),
      .next_rem (nrem),
      .qbit     (qbit)
   );

   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         state        <= IDLE;
         dvd          <= '0;
         dvs          <= '0;
         prem         <= '0;
         cnt          <= '0;
         div_bit_quot <= '0;
         div_bit_rem  <= '0;
         div_bit_busy <= 1'b0;
         div_bit_done <= 1'b0;
         div_bit_dz   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               div_bit_done <= 1'b0;
               if (div_bit_exe) begin
                  dvd          <= div_bit1;
                  dvs          <= div_bit2;
                  prem         <= '0;
                  cnt          <= DIV_CNT_W'(DIV_N_W - 1);
                  div_bit_busy <= 1'b1;
                  if (div_bit2 == '0) begin
                     state        <= DONE;
                     div_bit_done <= 1'b1;
                     div_bit_quot <= DIV_DZ_QUOT;
                     div_bit_rem  <= div_bit1[DIV_D_W-1:0];
                     div_bit_dz   <= 1'b1;
                  end else begin
                     state        <= RUN;
                     div_bit_dz   <= 1'b0;
                  end
               end
            end
            RUN: begin
               prem <= nrem;
               dvd  <= {dvd[DIV_N_W-2:0], qbit};
               if (cnt == '0) begin
                  state        <= DONE;
                  div_bit_done <= 1'b1;
                  div_bit_quot <= {dvd[DIV_N_W-2:0], qbit};
                  div_bit_rem  <= nrem;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state        <= IDLE;
               div_bit_busy <= 1'b0;
               div_bit_done <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               div_bit_busy <= 1'b0;
               div_bit_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_bit.sv
// Randomized self-checking bench for div_bit against an arithmetic model.
module tb_div_bit;

   logic        m_clock = 1'b0;
   logic        p_reset = 1'b1;
   logic        div_bit_exe = 1'b0;
   logic [18:0] div_bit1 = '0;
   logic [15:0] div_bit2 = '0;
   logic [18:0] div_bit_quot;
   logic [15:0] div_bit_rem;
   logic        div_bit_busy;
   logic        div_bit_done;
   logic        div_bit_dz;

   always #5 m_clock = ~m_clock;

   div_bit dut (
      .p_reset      (p_reset),
      .m_clock      (m_clock),
      .div_bit1     (div_bit1),
      .div_bit2     (div_bit2),
      .div_bit_exe  (div_bit_exe),
      .div_bit_quot (div_bit_quot),
      .div_bit_rem  (div_bit_rem),
      .div_bit_busy (div_bit_busy),
      .div_bit_done (div_bit_done),
      .div_bit_dz   (div_bit_dz)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: an accepted op publishes a/b, a%b after a fixed latency.
   bit          m_busy, m_done, m_dz, p_dz;
   int          m_t;
   logic [18:0] m_q, p_q, m_a;
   logic [15:0] m_r, p_r, m_b;

   always @(posedge m_clock) begin
      int a, b;
      if (p_reset) begin
         m_busy = 0; m_done = 0; m_dz = 0; m_t = 0;
         m_q = '0; m_r = '0;
      end else if (m_done) begin
         m_done = 0;
         m_busy = 0;
      end else if (m_busy) begin
         m_t--;
         if (m_t == 0) begin
            m_done = 1;
            m_q = p_q; m_r = p_r; m_dz = p_dz;
         end
      end else if (div_bit_exe) begin
         m_busy = 1;
         m_a = div_bit1;
         m_b = div_bit2;
         a = int'(div_bit1);
         b = int'(div_bit2);
         if (b == 0) begin
            m_q = 19'h7FFFF; m_r = 16'(a); m_dz = 1;
            m_done = 1;
         end else begin
            p_q = 19'(a / b); p_r = 16'(a % b); p_dz = 0;
            m_dz = 0;
            m_t = 19;
         end
      end
   end

   always @(negedge m_clock) begin
      if (chk_en) begin
         check("busy", 64'(div_bit_busy), 64'(m_busy));
         check("done", 64'(div_bit_done), 64'(m_done));
         check("quot", 64'(div_bit_quot), 64'(m_q));
         check("rem", 64'(div_bit_rem), 64'(m_r));
         check("dz", 64'(div_bit_dz), 64'(m_dz));
         if (div_bit_done && !div_bit_dz) begin
            check("identity", 64'(div_bit_quot) * 64'(m_b) + 64'(div_bit_rem),
                  64'(m_a));
            check("rem_lt_div", 64'(div_bit_rem < m_b), 64'd1);
         end
      end
   end

   task automatic start_op(input logic [18:0] a, input logic [15:0] b);
      @(negedge m_clock);
      div_bit1 = a;
      div_bit2 = b;
      div_bit_exe = 1'b1;
      @(negedge m_clock);
      div_bit_exe = 1'b0;
      div_bit1 = 19'($urandom);
      div_bit2 = 16'($urandom);
   endtask

   // Called at the negedge of the cycle after the accepting edge.
   task automatic wait_done(output int lat, output int busy_n, input bit junk);
      int n;
      n = 1;
      busy_n = 0;
      lat = -1;
      while (n <= 40) begin
         if (div_bit_busy) busy_n++;
         if (div_bit_done) begin
            lat = n - 1;
            break;
         end
         if (junk) begin
            div_bit_exe = ($urandom_range(0, 5) == 0);
            div_bit1 = 19'($urandom);
            div_bit2 = 16'($urandom);
         end
         n++;
         @(negedge m_clock);
      end
      div_bit_exe = 1'b0;
      if (lat < 0) begin
         errors++;
         $display("FAIL timeout: done never seen after %0d cycles", n);
      end
   endtask

   task automatic run_lit(input string nm, input logic [18:0] a,
                          input logic [15:0] b, input logic [18:0] eq,
                          input logic [15:0] er, input bit edz,
                          input int elat, input int ebusy);
      int lat, bn;
      start_op(a, b);
      wait_done(lat, bn, 1'b0);
      check({nm, "_quot"}, 64'(div_bit_quot), 64'(eq));
      check({nm, "_rem"}, 64'(div_bit_rem), 64'(er));
      check({nm, "_dz"}, 64'(div_bit_dz), 64'(edz));
      check({nm, "_lat"}, 64'(lat), 64'(elat));
      check({nm, "_busy"}, 64'(bn), 64'(ebusy));
   endtask

   initial begin
      int lat, bn, dones;
      logic [15:0] b;

      repeat (3) @(negedge m_clock);
      p_reset = 1'b0;
      chk_en = 1'b1;
      check("rst_quot", 64'(div_bit_quot), 64'd0);
      check("rst_rem", 64'(div_bit_rem), 64'd0);
      check("rst_busy", 64'(div_bit_busy), 64'd0);
      check("rst_done", 64'(div_bit_done), 64'd0);
      check("rst_dz", 64'(div_bit_dz), 64'd0);

      run_lit("basic", 19'd100, 16'd7, 19'd14, 16'd2, 1'b0, 19, 20);
      run_lit("max_ff", 19'h7FFFF, 16'hFFFF, 19'd8, 16'd7, 1'b0, 19, 20);
      run_lit("max_one", 19'h7FFFF, 16'd1, 19'h7FFFF, 16'd0, 1'b0, 19, 20);
      run_lit("dz", 19'd1234, 16'd0, 19'h7FFFF, 16'd1234, 1'b1, 0, 1);
      run_lit("after_dz", 19'd100, 16'd7, 19'd14, 16'd2, 1'b0, 19, 20);

      start_op(19'd100, 16'd7);
      dones = 0;
      for (int n = 1; n <= 30; n++) begin
         div_bit_exe = 1'b0;
         if (n == 5) begin
            div_bit_exe = 1'b1; div_bit1 = 19'd50; div_bit2 = 16'd5;
         end
         if (div_bit_done) begin
            dones++;
            div_bit_exe = 1'b1; div_bit1 = 19'd50; div_bit2 = 16'd5;
         end
         @(negedge m_clock);
      end
      div_bit_exe = 1'b0;
      check("busy_dones", 64'(dones), 64'd1);
      check("busy_quot", 64'(div_bit_quot), 64'd14);
      check("busy_rem", 64'(div_bit_rem), 64'd2);

      start_op(19'd1000, 16'd3);
      repeat (9) @(negedge m_clock);
      p_reset = 1'b1;
      div_bit_exe = 1'b1;
      div_bit1 = 19'd77;
      div_bit2 = 16'd5;
      @(negedge m_clock);
      check("mid_rst_quot", 64'(div_bit_quot), 64'd0);
      check("mid_rst_rem", 64'(div_bit_rem), 64'd0);
      check("mid_rst_busy", 64'(div_bit_busy), 64'd0);
      check("mid_rst_done", 64'(div_bit_done), 64'd0);
      check("mid_rst_dz", 64'(div_bit_dz), 64'd0);
      p_reset = 1'b0;
      div_bit_exe = 1'b0;
      @(negedge m_clock);
      check("mid_rst_idle", 64'(div_bit_busy), 64'd0);
      run_lit("after_rst", 19'd1000, 16'd3, 19'd333, 16'd1, 1'b0, 19, 20);

      repeat (2000) begin
         if ($urandom_range(0, 9) == 0) b = 16'd0;
         else if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 15));
         else b = 16'($urandom_range(1, 65535));
         start_op(19'($urandom_range(0, 19'h7FFFF)), b);
         wait_done(lat, bn, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge m_clock);
      end

      repeat (3) @(negedge m_clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
